// File: rtl/key_entry_ctrl.sv
// Keyboard-entry and result-display controller: builds a hex operand from key events,
// hands it to the compute block over valid/ready and holds the returned result on the display.
module key_entry_ctrl #(
    parameter int DIGITS      = 8,
    parameter int OPER_DIGITS = 4,
    parameter int RES_DIGITS  = 4,
    parameter int TIMEOUT     = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     key_valid,
    input  logic [1:0]               key_kind,
    input  logic [3:0]               key_code,
    output logic                     op_valid,
    output logic [4*OPER_DIGITS-1:0] op_data,
    input  logic                     op_ready,
    input  logic                     res_valid,
    input  logic [4*RES_DIGITS-1:0]  res_data,
    input  logic                     res_error,
    output logic [4*DIGITS-1:0]      numb,
    output logic [DIGITS-1:0]        mask,
    output logic                     error,
    output logic                     busy
);

    localparam int NW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [1:0] K_DIGIT = 2'b00;
    localparam logic [1:0] K_ENTER = 2'b01;
    localparam logic [1:0] K_BACK  = 2'b10;
    localparam logic [1:0] K_CLEAR = 2'b11;

    typedef enum logic [1:0] {S_ENTRY, S_ISSUE, S_WAIT, S_SHOW} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;

    // Digits at or above the entered count are blanked; with nothing entered all are blank.
    function automatic logic [DIGITS-1:0] entry_mask(input logic [CW-1:0] c);
        logic [DIGITS-1:0] m;
        for (int i = 0; i < DIGITS; i++) m[i] = (CW'(i) >= c);
        return m;
    endfunction

    function automatic logic [DIGITS-1:0] result_mask();
        logic [DIGITS-1:0] m;
        for (int i = 0; i < DIGITS; i++) m[i] = (i >= RES_DIGITS);
        return m;
    endfunction

    function automatic logic [NW-1:0] shift_in(input logic [NW-1:0] v, input logic [3:0] k);
        logic [NW-1:0] t;
        t      = v << 4;
        t[3:0] = k;
        return t;
    endfunction

    function automatic logic [NW-1:0] zext_res(input logic [4*RES_DIGITS-1:0] r);
        logic [NW-1:0] t;
        t                    = '0;
        t[4*RES_DIGITS-1:0]  = r;
        return t;
    endfunction

    function automatic logic [NW-1:0] zext_key(input logic [3:0] k);
        logic [NW-1:0] t;
        t      = '0;
        t[3:0] = k;
        return t;
    endfunction

    // numb does not move while the operand is offered, so the slice is a stable registered value.
    assign op_data = numb[4*OPER_DIGITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_ENTRY;
            cnt      <= '0;
            numb     <= '0;
            mask     <= '1;
            error    <= 1'b0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
            timer    <= '0;
        end else if (key_valid && key_kind == K_CLEAR) begin
            state    <= S_ENTRY;
            cnt      <= '0;
            numb     <= '0;
            mask     <= '1;
            error    <= 1'b0;
            op_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                S_ENTRY: begin
                    if (key_valid) begin
                        case (key_kind)
                            K_DIGIT: if (cnt < CW'(DIGITS)) begin
                                numb <= shift_in(numb, key_code);
                                cnt  <= cnt + 1'b1;
                                mask <= entry_mask(cnt + 1'b1);
                            end
                            K_BACK: if (cnt != '0) begin
                                numb <= numb >> 4;
                                cnt  <= cnt - 1'b1;
                                mask <= entry_mask(cnt - 1'b1);
                            end
                            K_ENTER: if (cnt != '0) begin
                                state    <= S_ISSUE;
                                op_valid <= 1'b1;
                                busy     <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_ISSUE: begin
                    if (op_ready) begin
                        state    <= S_WAIT;
                        op_valid <= 1'b0;
                        timer    <= '0;
                    end
                end
                S_WAIT: begin
                    if (res_valid) begin
                        numb  <= zext_res(res_data);
                        mask  <= result_mask();
                        error <= res_error;
                        busy  <= 1'b0;
                        state <= S_SHOW;
                    end else if (TIMEOUT > 0 && timer == TMAX) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_SHOW;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_SHOW: begin
                    if (key_valid) begin
                        case (key_kind)
                            K_DIGIT: begin
                                numb  <= zext_key(key_code);
                                cnt   <= CW'(1);
                                mask  <= entry_mask(CW'(1));
                                error <= 1'b0;
                                state <= S_ENTRY;
                            end
                            K_BACK: begin
                                numb  <= '0;
                                cnt   <= '0;
                                mask  <= '1;
                                error <= 1'b0;
                                state <= S_ENTRY;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= S_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed scenarios then random key/handshake traffic against a queue-based model.
module tb_key_entry_ctrl;

    localparam int DIG = 8;
    localparam int OPD = 4;
    localparam int RSD = 4;
    localparam int TMO = 10;

    logic            clk;
    logic            reset;
    logic            key_valid;
    logic [1:0]      key_kind;
    logic [3:0]      key_code;
    logic            op_valid;
    logic [4*OPD-1:0] op_data;
    logic            op_ready;
    logic            res_valid;
    logic [4*RSD-1:0] res_data;
    logic            res_error;
    logic [4*DIG-1:0] numb;
    logic [DIG-1:0]  mask;
    logic            error;
    logic            busy;

    key_entry_ctrl #(.DIGITS(DIG), .OPER_DIGITS(OPD), .RES_DIGITS(RSD), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .key_valid(key_valid), .key_kind(key_kind), .key_code(key_code),
        .op_valid(op_valid), .op_data(op_data), .op_ready(op_ready), .res_valid(res_valid),
        .res_data(res_data), .res_error(res_error), .numb(numb), .mask(mask), .error(error), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: entered digits as a list, plus what the display is currently showing.
    int          digs[$];
    bit          offering, awaiting, showing, derr;
    int          wcycles;
    logic [31:0] disp;
    logic [7:0]  dmask;

    function automatic logic [31:0] digs_value();
        logic [31:0] v = 0;
        foreach (digs[k]) v = (v << 4) | 32'(digs[k]);
        return v;
    endfunction

    function automatic logic [7:0] digs_mask();
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = (i >= digs.size());
        return m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        digs.delete();
        offering = 0; awaiting = 0; showing = 0; derr = 0;
    endtask

    task automatic model_step();
        if (reset) model_clear();
        else if (key_valid && key_kind == 2'b11) model_clear();
        else if (awaiting) begin
            if (res_valid) begin
                awaiting = 0; showing = 1;
                disp = 32'(res_data); dmask = 8'hF0; derr = res_error;
            end else begin
                wcycles++;
                if (wcycles == TMO) begin
                    awaiting = 0; showing = 1;
                    disp = digs_value(); dmask = digs_mask(); derr = 1;
                end
            end
        end else if (offering) begin
            if (op_ready) begin offering = 0; awaiting = 1; wcycles = 0; end
        end else if (showing) begin
            if (key_valid && key_kind == 2'b00) begin
                digs.delete(); digs.push_back(int'(key_code)); showing = 0; derr = 0;
            end else if (key_valid && key_kind == 2'b10) begin
                digs.delete(); showing = 0; derr = 0;
            end
        end else if (key_valid) begin
            case (key_kind)
                2'b00: if (digs.size() < 8) digs.push_back(int'(key_code));
                2'b10: if (digs.size() > 0) void'(digs.pop_back());
                2'b01: if (digs.size() > 0) offering = 1;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        chk("numb", numb, showing ? disp : digs_value());
        chk("mask", mask, showing ? dmask : digs_mask());
        chk("error", error, derr);
        chk("op_valid", op_valid, offering);
        chk("busy", busy, offering | awaiting);
        if (offering) chk("op_data", op_data, digs_value() & 32'hFFFF);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_outputs();
    endtask

    task automatic key(input logic [1:0] kind, input logic [3:0] code);
        key_valid = 1'b1; key_kind = kind; key_code = code;
        tick();
        key_valid = 1'b0;
    endtask

    // Enter an operand and complete the transfer so the DUT sits in its result-wait phase.
    task automatic to_wait(input logic [3:0] d);
        key(2'b00, d);
        key(2'b01, 4'h0);
        op_ready = 1'b1;
        tick();
        op_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int opv_cnt;
        int n;
        reset = 1'b1; key_valid = 1'b0; key_kind = 2'b00; key_code = 4'h0;
        op_ready = 1'b0; res_valid = 1'b0; res_data = '0; res_error = 1'b0;
        model_clear(); disp = 0; dmask = 8'hFF; wcycles = 0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_numb", numb, 32'h0);
        chk("rst_mask", mask, 8'hFF);
        chk("rst_busy", busy, 1'b0);

        key(2'b00, 4'h1); key(2'b00, 4'h2); key(2'b00, 4'h3);
        chk("d123_numb", numb, 32'h00000123);
        chk("d123_mask", mask, 8'hF8);
        key(2'b10, 4'h0);
        chk("bs_numb", numb, 32'h12);
        chk("bs_mask", mask, 8'hFC);

        key(2'b11, 4'h0);
        for (int i = 1; i <= 9; i++) key(2'b00, 4'(i));
        chk("nine_numb", numb, 32'h12345678);
        chk("nine_mask", mask, 8'h00);

        key(2'b11, 4'h0);
        key(2'b00, 4'hA); key(2'b00, 4'hB); key(2'b00, 4'hC); key(2'b00, 4'hD);
        key(2'b01, 4'h0);
        opv_cnt = 0;
        op_ready = 1'b0;
        repeat (5) begin
            if (op_valid) opv_cnt++;
            chk("hold_op_data", op_data, 16'hABCD);
            tick();
        end
        if (op_valid) opv_cnt++;
        op_ready = 1'b1; res_valid = 1'b1; res_data = 16'h9999;
        tick();
        op_ready = 1'b0; res_valid = 1'b0;
        chk("opv_cycles", opv_cnt, 6);
        chk("opv_drop", op_valid, 1'b0);
        res_valid = 1'b1; res_data = 16'h0042; res_error = 1'b0;
        tick();
        res_valid = 1'b0;
        chk("res_numb", numb, 32'h42);
        chk("res_mask", mask, 8'hF0);
        chk("res_busy", busy, 1'b0);

        to_wait(4'h5);
        n = 0;
        while (!error && n < 20) begin tick(); n++; end
        chk("timeout_cycles", n, TMO);
        key(2'b00, 4'h7);
        chk("after_to_numb", numb, 32'h7);
        chk("after_to_mask", mask, 8'hFE);
        chk("after_to_err", error, 1'b0);

        to_wait(4'h3);
        tick();
        key(2'b11, 4'h0);
        tick();
        res_valid = 1'b1; res_data = 16'h1234;
        tick();
        res_valid = 1'b0;
        chk("stale_numb", numb, 32'h0);
        chk("stale_mask", mask, 8'hFF);

        key(2'b01, 4'h0);
        chk("enter_empty", op_valid, 1'b0);

        to_wait(4'h9);
        res_valid = 1'b1; res_data = 16'h00EE; res_error = 1'b1;
        key(2'b11, 4'h0);
        res_valid = 1'b0; res_error = 1'b0;
        chk("clr_win_numb", numb, 32'h0);
        chk("clr_win_mask", mask, 8'hFF);
        chk("clr_win_err", error, 1'b0);

        key(2'b00, 4'h4);
        key(2'b01, 4'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_opv", op_valid, 1'b0);
        chk("midrst_mask", mask, 8'hFF);

        for (int c = 0; c < 1500; c++) begin
            int r;
            reset     = ($urandom_range(0, 299) == 0);
            key_valid = ($urandom_range(0, 99) < 35);
            r = $urandom_range(0, 99);
            key_kind  = (r < 55) ? 2'b00 : (r < 75) ? 2'b01 : (r < 93) ? 2'b10 : 2'b11;
            key_code  = 4'($urandom_range(0, 15));
            op_ready  = ($urandom_range(0, 99) < 40);
            res_valid = ($urandom_range(0, 99) < 7);
            res_data  = 16'($urandom());
            res_error = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
